// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_restoring_divider_pkg;

    // Controller states; the unused encoding 2'd3 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus of the divider.
interface seq_restoring_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider_sub_stage.sv
// Combinational W-bit subtractor a + ~b + 1 as a ripple of full-adder cells.
module sub_stage #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);
    logic [W-1:0] b_inv;
    logic [W:0]   carry;

    assign b_inv = ~b;

    // Ripple the carry through one full-adder cell per bit, seeded with 1.
    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
            carry[i + 1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
        end
    end

    assign no_borrow = carry[W];
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned divider, one quotient bit per cycle (restoring).
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    // Partial remainder: its (N+1)-th bit is always zero after a step, so
    // only the low N bits are kept.
    logic [N-1:0]  r_q, r_d;
    logic          dbz_q, dbz_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_out_q, dbz_out_d;

    logic [N:0]    trial;
    logic [N:0]    diff;
    logic          no_borrow;
    logic [N-1:0]  r_step;
    logic [N-1:0]  q_step;
    logic          diff_msb_unused;

    assign trial           = {r_q, q_q[N-1]};
    assign diff_msb_unused = diff[N];

    sub_stage #(.W(N + 1)) u_sub (
        .a         (trial),
        .b         ({1'b0, d_q}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    // One shift-subtract step: keep the difference when it did not borrow.
    always_comb begin
        r_step = no_borrow ? diff[N-1:0] : trial[N-1:0];
        q_step = {q_q[N-2:0], no_borrow};
    end

    // Next-state logic for the controller, datapath and result registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        d_d       = d_q;
        r_d       = r_q;
        dbz_d     = dbz_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_out_d = dbz_out_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = CNT_LAST;
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    r_d     = '0;
                    dbz_d   = (bus.divisor == '0);
                end
            end
            RUN: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    quot_d    = q_step;
                    rem_d     = r_step;
                    dbz_out_d = dbz_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            q_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            d_q       <= d_d;
            r_q       <= r_d;
            dbz_q     <= dbz_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_out_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized self-checking bench for seq_restoring_divider at N=8 and N=16.
module tb_seq_restoring_divider;
   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   seq_restoring_divider_if #(.N(8))  bus8 ();
   seq_restoring_divider_if #(.N(16)) bus16 ();

   seq_restoring_divider #(.N(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   seq_restoring_divider #(.N(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16.slave)
   );

   // Count one comparison and report it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int w);
      return (w == 8) ? bus8.ready : bus16.ready;
   endfunction

   function automatic logic dn(input int w);
      return (w == 8) ? bus8.done : bus16.done;
   endfunction

   function automatic logic [15:0] quo(input int w);
      return (w == 8) ? {8'h00, bus8.quotient} : bus16.quotient;
   endfunction

   function automatic logic [15:0] rem(input int w);
      return (w == 8) ? {8'h00, bus8.remainder} : bus16.remainder;
   endfunction

   function automatic logic dbz(input int w);
      return (w == 8) ? bus8.div_by_zero : bus16.div_by_zero;
   endfunction

   task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
      if (w == 8) begin
         bus8.start    = s;
         bus8.dividend = a[7:0];
         bus8.divisor  = b[7:0];
      end else begin
         bus16.start    = s;
         bus16.dividend = a;
         bus16.divisor  = b;
      end
   endtask

   // Reference: plain integer division, all-ones quotient for a zero divisor.
   task automatic refDiv(input int w, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
      logic [15:0] mask;
      mask = (w == 8) ? 16'h00ff : 16'hffff;
      z = ((b & mask) == 16'h0);
      if (z) begin
         q = mask;
         r = a & mask;
      end else begin
         q = (a & mask) / (b & mask);
         r = (a & mask) % (b & mask);
      end
   endtask

   // Issue one divide at the first ready edge and check timing and results.
   // Entered and left on a falling edge; optional noise on start/operands.
   task automatic applyStimulus(input int w, input logic [15:0] a, input logic [15:0] b,
                                input bit noise, output logic [15:0] qo, output logic [15:0] ro);
      logic [15:0] eq, er, pq;
      logic        ez;
      int          cnt;
      bit          seen, rdyHigh;
      refDiv(w, a, b, eq, er, ez);
      cnt = 0;
      while (!rdy(w) && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("ready_before_start", rdy(w), 1'b1);
      pq = quo(w);
      drive(w, 1'b1, a, b);
      @(negedge clk);
      drive(w, 1'b0, a, b);
      checkOutput("ready_low_after_accept", rdy(w), 1'b0);
      checkOutput("quotient_held_in_run", quo(w), pq);
      cnt     = 0;
      seen    = 0;
      rdyHigh = 0;
      while (!seen && cnt < w + 5) begin
         if (noise) drive(w, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
         @(negedge clk);
         cnt++;
         if (rdy(w)) rdyHigh = 1;
         if (dn(w)) seen = 1;
      end
      drive(w, 1'b0, a, b);
      checkOutput("done_seen", seen, 1'b1);
      checkOutput("done_latency", cnt, w);
      checkOutput("ready_stayed_low", rdyHigh, 1'b0);
      checkOutput("quotient", quo(w), eq);
      checkOutput("remainder", rem(w), er);
      checkOutput("div_by_zero", dbz(w), ez);
      qo = quo(w);
      ro = rem(w);
      @(negedge clk);
      checkOutput("done_single_cycle", dn(w), 1'b0);
      checkOutput("ready_returned", rdy(w), 1'b1);
      checkOutput("quotient_held_after", quo(w), eq);
   endtask

   initial begin
      logic [15:0] q, r, a, b;
      rst_n = 1'b0;
      drive(8, 1'b0, 16'h0, 16'h0);
      drive(16, 1'b0, 16'h0, 16'h0);
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", bus8.ready, 1'b1);
      checkOutput("reset_done", bus8.done, 1'b0);
      checkOutput("reset_quotient", bus8.quotient, 8'd0);
      checkOutput("reset_remainder", bus8.remainder, 8'd0);
      checkOutput("reset_dbz", bus8.div_by_zero, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(8, 16'd100, 16'd7, 1'b0, q, r);
      checkOutput("dir_100_7_q", q, 16'd14);
      checkOutput("dir_100_7_r", r, 16'd2);
      applyStimulus(8, 16'd255, 16'd1, 1'b0, q, r);
      checkOutput("dir_255_1_q", q, 16'd255);
      applyStimulus(8, 16'd5, 16'd9, 1'b0, q, r);
      checkOutput("dir_5_9_r", r, 16'd5);
      applyStimulus(8, 16'd200, 16'd0, 1'b0, q, r);
      checkOutput("dir_200_0_q", q, 16'd255);
      checkOutput("dir_200_0_r", r, 16'd200);
      applyStimulus(8, 16'd10, 16'd3, 1'b0, q, r);
      checkOutput("dir_10_3_dbz", bus8.div_by_zero, 1'b0);
      applyStimulus(8, 16'd90, 16'd4, 1'b1, q, r);
      checkOutput("dir_90_4_q", q, 16'd22);
      checkOutput("dir_90_4_r", r, 16'd2);

      // Abort a divide with reset three cycles into RUN.
      drive(8, 1'b1, 16'd77, 16'd3);
      @(negedge clk);
      drive(8, 1'b0, 16'd77, 16'd3);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("abort_no_done", bus8.done, 1'b0);
      end
      checkOutput("abort_ready", bus8.ready, 1'b1);
      checkOutput("abort_quotient", bus8.quotient, 8'd0);
      checkOutput("abort_remainder", bus8.remainder, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("abort_still_no_done", bus8.done, 1'b0);
      applyStimulus(8, 16'd77, 16'd8, 1'b0, q, r);
      checkOutput("dir_77_8_q", q, 16'd9);
      checkOutput("dir_77_8_r", r, 16'd5);

      applyStimulus(16, 16'd65535, 16'd255, 1'b0, q, r);
      checkOutput("dir16_q", q, 16'd257);
      checkOutput("dir16_r", r, 16'd0);

      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
         if ($urandom_range(0, 3) == 0) b = b & 16'h000f;
         applyStimulus(8, a, b, bit'($urandom_range(0, 1)), q, r);
      end
      for (int i = 0; i < 200; i++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
         if ($urandom_range(0, 2) == 0) b = b & 16'h00ff;
         applyStimulus(16, a, b, bit'($urandom_range(0, 1)), q, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
